// File: rtl/median_engine.sv
// ============================================================================
//  Module   : median_engine
//  Purpose  : Self-sequencing rank-order filter. Collects a window of NUM
//             unsigned samples over a valid/ready stream, then selects the
//             K-th largest sample by repeated max-elimination passes.
//             Default K = (NUM-1)/2, which is the median.
//  Options  : MED_RANK_EN - adds a RANK input; K is sampled from RANK with
//             the last sample of each window, clamped to NUM-1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_engine #(
    parameter int WIDTH = 8,
    parameter int NUM   = 9
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [WIDTH-1:0]        DI,
    input  logic                    DSI,
    output logic                    READY,
    output logic [WIDTH-1:0]        DO,
    output logic                    DSO
`ifdef MED_RANK_EN
    ,
    input  logic [$clog2(NUM)-1:0]  RANK
`endif
);

    localparam int             IW    = $clog2(NUM);
    localparam int             SW    = $clog2(NUM + 1);
    localparam logic [IW-1:0]  LAST  = IW'(NUM - 1);
    localparam logic [IW-1:0]  MED_K = IW'((NUM - 1) / 2);
    localparam logic [SW-1:0]  SCAN_END = SW'(NUM);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    bank [NUM];
    logic [IW-1:0]       count;
    logic [IW-1:0]       pass_cnt;
    logic [SW-1:0]       scan;
    logic [WIDTH-1:0]    maxr;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       k;
    logic [IW-1:0]       k_next;

`ifdef MED_RANK_EN
    // Requested rank, clamped so out-of-range values select the minimum
    always_comb begin
        k_next = RANK;
        if (RANK > LAST) begin
            k_next = LAST;
        end
    end
`else
    assign k_next = MED_K;
`endif

    // Control FSM and datapath: every pass runs scan=0..NUM-1 for the max,
    // then scan==NUM is either the remove cycle or, on the final pass, the
    // result-load cycle. Each pass is therefore exactly NUM+1 cycles long.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= LOAD;
            count    <= '0;
            pass_cnt <= '0;
            scan     <= '0;
            maxr     <= '0;
            idx      <= '0;
            k        <= MED_K;
            DO       <= '0;
            DSO      <= 1'b0;
            READY    <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    DSO <= 1'b0;
                    if (DSI) begin
                        bank[count] <= DI;
                        if (count == LAST) begin
                            state    <= SORT;
                            READY    <= 1'b0;
                            count    <= '0;
                            pass_cnt <= '0;
                            scan     <= '0;
                            maxr     <= '0;
                            idx      <= '0;
                            k        <= k_next;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                SORT: begin
                    if (scan != SCAN_END) begin
                        // Strict compare keeps the lowest index on ties
                        if (bank[scan[IW-1:0]] > maxr) begin
                            maxr <= bank[scan[IW-1:0]];
                            idx  <= scan[IW-1:0];
                        end
                        scan <= scan + 1'b1;
                    end else if (pass_cnt == k) begin
                        DO    <= maxr;
                        DSO   <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Zero never beats a surviving unsigned value
                        bank[idx] <= '0;
                        pass_cnt  <= pass_cnt + 1'b1;
                        scan      <= '0;
                        maxr      <= '0;
                        idx       <= '0;
                    end
                end

                DONE: begin
                    DSO   <= 1'b0;
                    READY <= 1'b1;
                    count <= '0;
                    state <= LOAD;
                end

                default: begin
                    state <= LOAD;
                    READY <= 1'b1;
                    DSO   <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_median_engine.sv
// ============================================================================
//  Module   : tb_median_engine
//  Purpose  : Directed self-checking bench for median_engine (NUM=9, WIDTH=8)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_median_engine;

    localparam int WIDTH = 8;
    localparam int NUM   = 9;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [WIDTH-1:0] DI  = '0;
    logic             DSI = 1'b0;
    logic             READY;
    logic [WIDTH-1:0] DO;
    logic             DSO;
`ifdef MED_RANK_EN
    logic [3:0]       RANK = 4'd4;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t_acc    = 0;

    logic [7:0] w_basic  [9] = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4, 8'd6};
    logic [7:0] w_ties   [9] = '{8'd7, 8'd7, 8'd7, 8'd1, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9};
    logic [7:0] w_ff     [9] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] w_zero   [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] w_fresh  [9] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
    logic [7:0] w_s1     [9] = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80, 8'd90};
    logic [7:0] w_s2     [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd200};
    logic [7:0] w_s3     [9] = '{8'd255, 8'd0, 8'd128, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2};

    median_engine #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .DI    (DI),
        .DSI   (DSI),
        .READY (READY),
        .DO    (DO),
        .DSO   (DSO)
`ifdef MED_RANK_EN
        ,
        .RANK  (RANK)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Feed one window; called and returns at #1 after a rising edge
    task automatic send(input logic [7:0] w [9], input bit gaps);
        int guard;
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge CLK);
                    #1;
                end
            end
            DI  = w[i];
            DSI = 1'b1;
            guard = 0;
            while (!READY && guard < 200) begin
                @(posedge CLK);
                #1;
                guard++;
            end
            if (guard >= 200) check("ready_timeout", 32'd0, 32'd1);
            @(posedge CLK);
            #1;
            DSI   = 1'b0;
            t_acc = cyc;
        end
    endtask

    // Wait for the strobe, then check value, latency and strobe shape
    task automatic wait_result(input string tag, input logic [31:0] exp_do,
                               input int exp_lat, input bit junk);
        bit seen;
        seen = 1'b0;
        for (int g = 0; g < 300 && !seen; g++) begin
            if (junk) begin
                DSI = 1'b1;
                DI  = 8'hFF;
            end
            @(posedge CLK);
            #1;
            if (DSO) seen = 1'b1;
        end
        DSI = 1'b0;
        if (!seen) begin
            check({tag, " dso_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " do"}, 32'(DO), exp_do);
            if (exp_lat > 0) check({tag, " latency"}, 32'(cyc - t_acc), 32'(exp_lat));
            check({tag, " ready_in_done"}, 32'(READY), 32'd0);
            @(posedge CLK);
            #1;
            check({tag, " dso_one_cycle"}, 32'(DSO), 32'd0);
            check({tag, " ready_after"}, 32'(READY), 32'd1);
            check({tag, " do_hold"}, 32'(DO), exp_do);
        end
    endtask

    initial begin
        bit stray;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("reset do", 32'(DO), 32'd0);
        check("reset dso", 32'(DSO), 32'd0);
        check("reset ready", 32'(READY), 32'd1);

        // Basic median with READY low through the sort
        send(w_basic, 1'b0);
        check("basic ready_after_accept", 32'(READY), 32'd0);
        wait_result("basic", 32'd5, 50, 1'b0);

        // Ties and extremes
        send(w_ties, 1'b0);
        wait_result("ties", 32'd7, 50, 1'b0);
        send(w_ff, 1'b0);
        wait_result("all_ff", 32'hFF, 50, 1'b0);
        send(w_zero, 1'b0);
        wait_result("all_zero", 32'h00, 50, 1'b0);

        // Gaps in LOAD, then junk DSI during SORT
        send(w_basic, 1'b1);
        wait_result("gaps", 32'd5, 50, 1'b0);
        send(w_basic, 1'b0);
        wait_result("sort_junk", 32'd5, 50, 1'b1);
        send(w_ties, 1'b0);
        wait_result("after_junk", 32'd7, 50, 1'b0);

        // Reset 20 cycles into SORT
        send(w_basic, 1'b0);
        repeat (20) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midreset do", 32'(DO), 32'd0);
        check("midreset dso", 32'(DSO), 32'd0);
        check("midreset ready", 32'(READY), 32'd1);
        stray = 1'b0;
        repeat (70) begin
            @(posedge CLK);
            #1;
            if (DSO) stray = 1'b1;
        end
        check("midreset no_dso", 32'(stray), 32'd0);
        send(w_fresh, 1'b0);
        wait_result("fresh", 32'd14, 50, 1'b0);

        // Streaming windows, DO holding between strobes
        send(w_s1, 1'b0);
        wait_result("stream1", 32'd50, 50, 1'b0);
        send(w_s2, 1'b0);
        check("stream2 hold_during_sort", 32'(DO), 32'd50);
        wait_result("stream2", 32'd5, 50, 1'b0);
        send(w_s3, 1'b0);
        check("stream3 hold_during_sort", 32'(DO), 32'd5);
        wait_result("stream3", 32'd16, 50, 1'b0);

`ifdef MED_RANK_EN
        RANK = 4'd0;
        send(w_basic, 1'b0);
        wait_result("rank0", 32'd9, 10, 1'b0);
        RANK = 4'd8;
        send(w_basic, 1'b0);
        wait_result("rank8", 32'd1, 90, 1'b0);
        RANK = 4'd15;
        send(w_basic, 1'b0);
        wait_result("rank15", 32'd1, 90, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
